video_format_sequencer: RTL and testbench
=========================================

// Module: video_format_sequencer
// PURPOSE
//  Sits between video_format_detector and monitor_interface2. Qualifies raw format codes over
//  several frames, commits a stable code to the monitor interface and LEDs, then raises a level
//  interrupt request. The request is held until the host acknowledges, with timeout/retry and a
//  sticky fault. Removes glitching format reports during input switching.
// PARAMETERS
//  FMT_W          8          width of format code; code 0 = no signal (FMT_NONE)
//  STABLE_FRAMES  4          consecutive qualifying frame ticks required to commit (>=1)
//  LOS_CYCLES     2_500_000  cycles without vsync edge treated as one frame tick (50 ms)
//  ACK_TIMEOUT    5_000_000  cycles in WAIT_ACK before a retry (100 ms @ 50 MHz)
//  MAX_RETRIES    3          retries before declaring fault
// PORTS
//  clk_50mhz_in  in   1      system clock, 50 MHz
//  reset_x       in   1      asynchronous reset, active-low
//  vsync_in      in   1      raw vsync, active-low pulse, asynchronous to clk
//  fmt_in        in   FMT_W  format code from detector
//  skip_init     in   1      1 = commit without raising irq_req (back button)
//  irq_ack       in   1      one-cycle pulse from monitor interface: host read format
//  fmt_out       out  FMT_W  committed format code
//  irq_req       out  1      level interrupt request to monitor interface
//  busy          out  1      1 when state != IDLE
//  fault         out  1      sticky: retries exhausted without ack
// BEHAVIOUR
//  - Reset: state IDLE; fmt_out=0, irq_req=0, busy=0, fault=0; all counters 0. Reset mid-operation
//    aborts immediately, including a pending request.
//  - vsync_in: 2-FF synchroniser, then falling-edge detect -> frame tick.
//    frame tick = edge OR los_cnt==LOS_CYCLES-1. los_cnt clears on every edge and on wrap.
//  - States: IDLE, QUALIFY, COMMIT, WAIT_ACK.
//  - IDLE: if fmt_in != fmt_out -> cand<=fmt_in, stab_cnt<=0, go QUALIFY.
//  - QUALIFY: fmt_in compared every cycle.
//    - fmt_in==fmt_out: abort to IDLE, or to WAIT_ACK if irq_req is still 1.
//    - other mismatch vs cand: cand<=fmt_in, stab_cnt<=0.
//    - Else, on tick: stab_cnt++. At the tick where stab_cnt==STABLE_FRAMES-1 -> COMMIT.
//  - COMMIT (1 cycle): fmt_out<=cand, fault<=0, ack_tmr<=0, retry_cnt<=0.
//    - skip_init=1: irq_req<=0, go IDLE.
//    - Else irq_req<=1, go WAIT_ACK.
//    - fmt_out and irq_req update on the same edge: 1 cycle after the final qualifying tick.
//  - WAIT_ACK:
//    - irq_ack=1: irq_req<=0, go IDLE. Ack wins over a timeout in the same cycle.
//    - fmt_in != fmt_out: cand<=fmt_in, go QUALIFY. irq_req stays 1, so the host reads the
//      newest code after the next commit.
//    - ack_tmr==ACK_TIMEOUT-1: ack_tmr<=0, retry_cnt++.
//      - retry_cnt==MAX_RETRIES: irq_req<=0, fault<=1, go IDLE.
//      - Else irq_req drops for exactly 1 cycle, then re-asserts (re-edge for the host).
//  - irq_ack outside WAIT_ACK is ignored. ack_tmr saturates; no counter may wrap.
//  - busy is combinational from state. All other outputs are registered.
// STRUCTURE
//  - video_pkg:
//    - FMT_W, FMT_NONE
//    - seq_state_t enum {IDLE, QUALIFY, COMMIT, WAIT_ACK}
//    - timing constants shared with video_format_detector
//  - Sub-module sync_edge_detect: 2-FF synchroniser plus falling-edge pulse, async active-low
//    reset. Reused for hsync later.
//  - Counter widths via $clog2 of their parameters.
// TESTING (STABLE_FRAMES=4; LOS_CYCLES and ACK_TIMEOUT scaled to 1000/2000 in sim)
//  1. fmt_in 0->0x05, held over 4 vsync falls -> fmt_out=0x05 and irq_req=1, both 1 cycle after
//     the 4th tick; irq_ack pulse -> irq_req=0 next cycle, busy=0.
//  2. 0x05->0x07 for 2 ticks, back to 0x05 -> no commit, fmt_out stays 0x05, FSM returns to IDLE.
//  3. Commit 0x07, no ack -> irq_req low 1 cycle at t=2000, 4000, 6000. At 8000: irq_req=0,
//     fault=1. Next commit clears fault.
//  4. vsync stuck, fmt_in=0 -> 4 LOS ticks (4000 cycles) -> fmt_out=0, irq_req=1.
//  5. skip_init=1, fmt change 0x03 -> fmt_out=0x03 after 4 ticks, irq_req stays 0.
//  6. Ack and timeout in the same cycle -> irq_req=0, fault=0, IDLE. reset_x low while
//     WAIT_ACK -> all outputs 0 asynchronously, without a clock edge.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video-path definitions: format code width, sequencer states and
// default frame/ack timing used by the format detector and sequencer.
package video_pkg;

  localparam int FMT_W = 8;
  localparam logic [FMT_W-1:0] FMT_NONE = '0;

  // 50 MHz system clock timing
  localparam int STABLE_FRAMES_DEF = 4;
  localparam int LOS_CYCLES_DEF    = 2_500_000;
  localparam int ACK_TIMEOUT_DEF   = 5_000_000;
  localparam int MAX_RETRIES_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    COMMIT,
    WAIT_ACK
  } seq_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous active-low strobe plus a
// one-cycle pulse on each falling edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall_pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Reset to the idle-high level so releasing reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall_pulse = prev & ~sync2;

endmodule

// File: rtl/video_format_sequencer.sv
// Qualifies detector format codes over several frames, commits a stable code
// and raises a level interrupt held until acknowledged, with timeout/retry.
module video_format_sequencer #(
  parameter int FMT_W         = video_pkg::FMT_W,
  parameter int STABLE_FRAMES = video_pkg::STABLE_FRAMES_DEF,
  parameter int LOS_CYCLES    = video_pkg::LOS_CYCLES_DEF,
  parameter int ACK_TIMEOUT   = video_pkg::ACK_TIMEOUT_DEF,
  parameter int MAX_RETRIES   = video_pkg::MAX_RETRIES_DEF
) (
  input  logic             clk_50mhz_in,
  input  logic             reset_x,
  input  logic             vsync_in,
  input  logic [FMT_W-1:0] fmt_in,
  input  logic             skip_init,
  input  logic             irq_ack,
  output logic [FMT_W-1:0] fmt_out,
  output logic             irq_req,
  output logic             busy,
  output logic             fault
);

  import video_pkg::*;

  localparam int LOS_W   = (LOS_CYCLES > 1) ? $clog2(LOS_CYCLES) : 1;
  localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int STAB_W  = $clog2(STABLE_FRAMES + 1);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [LOS_W-1:0]   LOS_LAST  = LOS_W'(LOS_CYCLES - 1);
  localparam logic [ACK_W-1:0]   ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_FRAMES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  seq_state_t         state;
  logic [FMT_W-1:0]   cand;
  logic [STAB_W-1:0]  stab_cnt;
  logic [ACK_W-1:0]   ack_tmr;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOS_W-1:0]   los_cnt;
  logic               reassert;
  logic               vsync_fall;
  logic               frame_tick;

  sync_edge_detect u_vsync_edge (
    .clk        (clk_50mhz_in),
    .rst_n      (reset_x),
    .async_in   (vsync_in),
    .fall_pulse (vsync_fall)
  );

  // Loss-of-signal: a silent LOS_CYCLES window counts as one frame
  assign frame_tick = vsync_fall || (los_cnt == LOS_LAST);

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      los_cnt <= '0;
    end else if (frame_tick) begin
      los_cnt <= '0;
    end else begin
      los_cnt <= los_cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state     <= IDLE;
      cand      <= '0;
      stab_cnt  <= '0;
      ack_tmr   <= '0;
      retry_cnt <= '0;
      fmt_out   <= '0;
      irq_req   <= 1'b0;
      fault     <= 1'b0;
      reassert  <= 1'b0;
    end else begin
      // A retry drop lasts one cycle; the request returns even if the FSM
      // has meanwhile moved to QUALIFY for a newer code.
      if (reassert) begin
        irq_req  <= 1'b1;
        reassert <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fmt_in != fmt_out) begin
            cand     <= fmt_in;
            stab_cnt <= '0;
            state    <= QUALIFY;
          end
        end

        QUALIFY: begin
          if (fmt_in == fmt_out) begin
            state <= (irq_req || reassert) ? WAIT_ACK : IDLE;
          end else if (fmt_in != cand) begin
            cand     <= fmt_in;
            stab_cnt <= '0;
          end else if (frame_tick) begin
            if (stab_cnt == STAB_LAST) begin
              state <= COMMIT;
            end else begin
              stab_cnt <= stab_cnt + 1'b1;
            end
          end
        end

        COMMIT: begin
          fmt_out   <= cand;
          fault     <= 1'b0;
          ack_tmr   <= '0;
          retry_cnt <= '0;
          reassert  <= 1'b0;
          if (skip_init) begin
            irq_req <= 1'b0;
            state   <= IDLE;
          end else begin
            irq_req <= 1'b1;
            state   <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (irq_ack) begin
            irq_req  <= 1'b0;
            reassert <= 1'b0;
            state    <= IDLE;
          end else if (fmt_in != fmt_out) begin
            cand     <= fmt_in;
            stab_cnt <= '0;
            state    <= QUALIFY;
          end else if (ack_tmr == ACK_LAST) begin
            ack_tmr <= '0;
            irq_req <= 1'b0;
            if (retry_cnt == RETRY_MAX) begin
              fault    <= 1'b1;
              reassert <= 1'b0;
              state    <= IDLE;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              reassert  <= 1'b1;
            end
          end else begin
            ack_tmr <= ack_tmr + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_format_sequencer.sv
// Directed bench for video_format_sequencer with scaled LOS/ack timing.
module tb_video_format_sequencer;

  localparam int FMT_W = 8;

  logic             clk_50mhz_in = 1'b0;
  logic             reset_x      = 1'b0;
  logic             vsync_in     = 1'b1;
  logic [FMT_W-1:0] fmt_in       = '0;
  logic             skip_init    = 1'b0;
  logic             irq_ack      = 1'b0;
  logic [FMT_W-1:0] fmt_out;
  logic             irq_req;
  logic             busy;
  logic             fault;

  int checks = 0;
  int errors = 0;

  video_format_sequencer #(
    .FMT_W         (FMT_W),
    .STABLE_FRAMES (4),
    .LOS_CYCLES    (1000),
    .ACK_TIMEOUT   (2000),
    .MAX_RETRIES   (3)
  ) dut (
    .clk_50mhz_in (clk_50mhz_in),
    .reset_x      (reset_x),
    .vsync_in     (vsync_in),
    .fmt_in       (fmt_in),
    .skip_init    (skip_init),
    .irq_ack      (irq_ack),
    .fmt_out      (fmt_out),
    .irq_req      (irq_req),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk_50mhz_in = ~clk_50mhz_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50mhz_in);
    #1;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    cyc(3);
    vsync_in = 1'b1;
    cyc(5);
  endtask

  // Clears the LOS counter, changes the code, then gives four vsync falls.
  // Returns 1 step after the commit edge (4 edges after the last fall is
  // driven); k3_* are sampled one edge earlier, while in COMMIT.
  task automatic qualify(input logic [FMT_W-1:0] code,
                         output logic [FMT_W-1:0] k3_fmt,
                         output logic k3_irq,
                         output logic k3_busy);
    vsync_pulse();
    fmt_in = code;
    cyc(1);
    repeat (3) vsync_pulse();
    vsync_in = 1'b0;
    cyc(3);
    k3_fmt  = fmt_out;
    k3_irq  = irq_req;
    k3_busy = busy;
    cyc(1);
    vsync_in = 1'b1;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
  endtask

  initial begin
    logic [FMT_W-1:0] k3_fmt;
    logic             k3_irq;
    logic             k3_busy;
    int               lows;
    int               n;

    // Reset state
    cyc(3);
    check("rst_fmt", fmt_out, 0);
    check("rst_irq", irq_req, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    reset_x = 1'b1;
    cyc(2);

    // 1: 0 -> 0x05, commit one cycle after the 4th tick, then ack
    qualify(8'h05, k3_fmt, k3_irq, k3_busy);
    check("t1_k3_fmt", k3_fmt, 8'h00);
    check("t1_k3_irq", k3_irq, 0);
    check("t1_k3_busy", k3_busy, 1);
    check("t1_fmt", fmt_out, 8'h05);
    check("t1_irq", irq_req, 1);
    check("t1_busy", busy, 1);
    cyc(3);
    ack_pulse();
    check("t1_ack_irq", irq_req, 0);
    check("t1_ack_busy", busy, 0);

    // 2: glitch to 0x07 for two frames, then back
    fmt_in = 8'h07;
    cyc(1);
    check("t2_busy_q", busy, 1);
    repeat (2) vsync_pulse();
    fmt_in = 8'h05;
    cyc(2);
    check("t2_busy", busy, 0);
    check("t2_fmt", fmt_out, 8'h05);
    repeat (4) vsync_pulse();
    check("t2_fmt_late", fmt_out, 8'h05);
    check("t2_irq", irq_req, 0);

    // 3: commit 0x07, never ack -> three retries then fault
    qualify(8'h07, k3_fmt, k3_irq, k3_busy);
    check("t3_irq0", irq_req, 1);
    lows = 0;
    for (int i = 1; i <= 8000; i++) begin
      cyc(1);
      if (i < 8000 && irq_req == 1'b0) lows++;
      if (i == 1999) check("t3_1999", irq_req, 1);
      if (i == 2000) check("t3_2000", irq_req, 0);
      if (i == 2001) check("t3_2001", irq_req, 1);
      if (i == 4000) check("t3_4000", irq_req, 0);
      if (i == 6000) check("t3_6000", irq_req, 0);
      if (i == 6001) check("t3_6001", irq_req, 1);
      if (i == 7999) check("t3_7999_fault", fault, 0);
    end
    check("t3_lows", lows, 3);
    check("t3_irq_end", irq_req, 0);
    check("t3_fault", fault, 1);
    check("t3_busy", busy, 0);

    // 4: vsync stuck, code 0 commits on LOS ticks; commit clears fault
    fmt_in = 8'h00;
    n = 0;
    while (fmt_out != 8'h00 && n < 4200) begin
      cyc(1);
      n++;
    end
    check("t4_window", (n >= 3000 && n <= 4005), 1);
    check("t4_fmt", fmt_out, 8'h00);
    check("t4_irq", irq_req, 1);
    check("t4_fault", fault, 0);
    ack_pulse();
    check("t4_ack_irq", irq_req, 0);

    // 5: skip_init commit without interrupt
    skip_init = 1'b1;
    qualify(8'h03, k3_fmt, k3_irq, k3_busy);
    check("t5_fmt", fmt_out, 8'h03);
    check("t5_k3_irq", k3_irq, 0);
    check("t5_irq", irq_req, 0);
    cyc(5);
    check("t5_irq_later", irq_req, 0);
    check("t5_busy", busy, 0);
    skip_init = 1'b0;

    // 6: ack lands in the same cycle as the first timeout
    qualify(8'h09, k3_fmt, k3_irq, k3_busy);
    check("t6_irq", irq_req, 1);
    cyc(1999);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check("t6_irq_ack", irq_req, 0);
    check("t6_fault", fault, 0);
    check("t6_busy", busy, 0);
    cyc(2);
    check("t6_no_reassert", irq_req, 0);

    // Newer code while waiting: request stays high through requalification
    qualify(8'h0A, k3_fmt, k3_irq, k3_busy);
    check("t7_fmt_a", fmt_out, 8'h0A);
    qualify(8'h0B, k3_fmt, k3_irq, k3_busy);
    check("t7_k3_irq", k3_irq, 1);
    check("t7_fmt_b", fmt_out, 8'h0B);
    check("t7_irq", irq_req, 1);

    // Asynchronous reset while WAIT_ACK, between clock edges
    #3 reset_x = 1'b0;
    #1;
    check("t8_fmt", fmt_out, 8'h00);
    check("t8_irq", irq_req, 0);
    check("t8_busy", busy, 0);
    check("t8_fault", fault, 0);
    cyc(2);
    reset_x = 1'b1;
    fmt_in  = 8'h00;
    cyc(3);
    check("t8_after_irq", irq_req, 0);
    check("t8_after_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
